// File: rtl/half_adder_pkg.sv
// Shared constants, occupancy encoding and counter arithmetic for half_adder_pipe.
// The statistics counters (enabled by HALF_ADDER_STATS_EN) use CNT_W and sat_add.
package half_adder_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   // Clamps at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/half_adder_skid.sv
// Two-entry valid/ready buffer: an output register plus one skid register.
// in_ready comes straight from a flop, so it never depends on out_ready in the same cycle.
module half_adder_skid
   import half_adder_pkg::*;
#(
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   occ_e          state_q, state_d;
   logic [DW-1:0] out_q, out_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_ready_q, in_ready_d;
   logic          in_fire, out_fire;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = (state_q != EMPTY) && out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               out_d   = in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            unique case ({in_fire, out_fire})
               2'b10: begin
                  skid_d  = in_data;
                  state_d = FULL;
               end
               2'b01: state_d = EMPTY;
               2'b11: out_d = in_data;
               default: ;
            endcase
         end
         FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_fire) begin
               out_d   = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_q;

endmodule

// File: rtl/half_adder_pipe.sv
// Registered lane-parallel half adder (Sum = A^B, Carry = A&B) behind a 2-entry skid buffer.
// Define HALF_ADDER_STATS_EN to add saturating txn_count / carry_count statistics ports.
module half_adder_pipe
   import half_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic [WIDTH-1:0] Carry
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] carry_count
`endif
);

   logic [WIDTH-1:0]   sum_c, carry_c;
   logic [2*WIDTH-1:0] payload_in, payload_out;

   // Results are formed before storage so the buffer only ever holds finished values.
   assign sum_c      = A ^ B;
   assign carry_c    = A & B;
   assign payload_in = {sum_c, carry_c};

   half_adder_skid #(
      .DW(2*WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (payload_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (payload_out)
   );

   assign Sum   = payload_out[2*WIDTH-1:WIDTH];
   assign Carry = payload_out[WIDTH-1:0];

`ifdef HALF_ADDER_STATS_EN
   logic             acc_fire;
   logic [CNT_W-1:0] pop_c;
   logic [CNT_W-1:0] txn_count_q, txn_count_d;
   logic [CNT_W-1:0] carry_count_q, carry_count_d;

   assign acc_fire = in_valid && in_ready;

   always_comb begin
      pop_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_c = pop_c + CNT_W'(carry_c[i]);
      end
      txn_count_d   = txn_count_q;
      carry_count_d = carry_count_q;
      if (acc_fire) begin
         txn_count_d   = sat_add(txn_count_q, CNT_W'(1));
         carry_count_d = sat_add(carry_count_q, pop_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_count_q   <= '0;
         carry_count_q <= '0;
      end else begin
         txn_count_q   <= txn_count_d;
         carry_count_q <= carry_count_d;
      end
   end

   assign txn_count   = txn_count_q;
   assign carry_count = carry_count_q;
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Bench for half_adder_pipe: directed and random traffic against a queue-based model.
module tb_half_adder_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A, B;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum, Carry;
`ifdef HALF_ADDER_STATS_EN
   logic [31:0]  txn_count, carry_count;
`endif

   int tests = 0;
   int fails = 0;

   // Model: an ordered list of up to two finished results plus counters.
   logic [2*W-1:0] q[$];
   longint         m_txn = 0;
   longint         m_carry = 0;

   always #5 clk = ~clk;

   half_adder_pipe #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Sum        (Sum),
      .Carry      (Carry)
`ifdef HALF_ADDER_STATS_EN
      ,
      .txn_count  (txn_count),
      .carry_count(carry_count)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         check({tag, ".sum"}, 64'(Sum), 64'(q[0][2*W-1:W]));
         check({tag, ".carry"}, 64'(Carry), 64'(q[0][W-1:0]));
      end
`ifdef HALF_ADDER_STATS_EN
      check({tag, ".txn_count"}, 64'(txn_count), 64'(m_txn));
      check({tag, ".carry_count"}, 64'(carry_count), 64'(m_carry));
`endif
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic step(input string tag, input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy);
      logic acc, drn;
      in_valid  = iv;
      A         = a;
      B         = b;
      out_ready = ordy;
      @(posedge clk);
      acc = iv && (q.size() < 2);
      drn = ordy && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) begin
         q.push_back({a ^ b, a & b});
         m_txn   = (m_txn + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_txn + 1;
         m_carry = (m_carry + $countones(a & b) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
                   : m_carry + $countones(a & b);
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_txn   = 0;
      m_carry = 0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b0;
      #12;
      check_outputs("reset");
      check("reset.sum0", 64'(Sum), 64'd0);
      check("reset.carry0", 64'(Carry), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Single-lane truth table in lane 0, one result per cycle.
      step("tt00", 1'b1, 8'h00, 8'h00, 1'b1);
      step("tt01", 1'b1, 8'h00, 8'h01, 1'b1);
      check("tt01.sum_lane0", 64'(Sum[0]), 64'd1);
      step("tt10", 1'b1, 8'h01, 8'h00, 1'b1);
      step("tt11", 1'b1, 8'h01, 8'h01, 1'b1);
      check("tt11.carry_lane0", 64'(Carry[0]), 64'd1);
      check("tt11.sum_lane0", 64'(Sum[0]), 64'd0);

      step("lanes", 1'b1, 8'hF0, 8'h3C, 1'b1);
      check("lanes.sum_CC", 64'(Sum), 64'hCC);
      check("lanes.carry_30", 64'(Carry), 64'h30);
      step("drain0", 1'b0, 8'h00, 8'h00, 1'b1);

      // Backpressure: three offers, two accepted.
      step("bp1", 1'b1, 8'hA5, 8'h5A, 1'b0);
      step("bp2", 1'b1, 8'hFF, 8'h0F, 1'b0);
      check("bp2.in_ready_low", 64'(in_ready), 64'd0);
      step("bp3", 1'b1, 8'h12, 8'h34, 1'b0);
      check("bp3.sum_first", 64'(Sum), 64'hFF);
      step("bp_rel1", 1'b0, 8'h00, 8'h00, 1'b1);
      check("bp_rel1.in_ready_high", 64'(in_ready), 64'd1);
      check("bp_rel1.carry_second", 64'(Carry), 64'h0F);
      step("bp_rel2", 1'b0, 8'h00, 8'h00, 1'b1);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 2) != 0));
      end

      // Asynchronous reset while full, checked before any clock edge.
      step("fill1", 1'b1, 8'h77, 8'h11, 1'b0);
      step("fill2", 1'b1, 8'h33, 8'hCC, 1'b0);
      step("fill3", 1'b1, 8'h33, 8'hCC, 1'b0);
      check("full.in_ready_low", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      check("async_rst.sum0", 64'(Sum), 64'd0);
      check("async_rst.carry0", 64'(Carry), 64'd0);
      in_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_outputs("post_rst");

      // Streaming counters: 10 transfers, 4 carry bits each.
      for (int i = 0; i < 10; i++) step("stream", 1'b1, 8'h0F, 8'h0F, 1'b1);
`ifdef HALF_ADDER_STATS_EN
      check("stream.txn_10", 64'(txn_count), 64'd10);
      check("stream.carry_40", 64'(carry_count), 64'd40);

      // Saturation from preloaded near-maximum counts.
      #2;
      force dut.txn_count_q = 32'hFFFF_FFFE;
      force dut.carry_count_q = 32'hFFFF_FFF4;
      #1;
      release dut.txn_count_q;
      release dut.carry_count_q;
      m_txn   = 64'hFFFF_FFFE;
      m_carry = 64'hFFFF_FFF4;
      for (int i = 0; i < 3; i++) step("sat", 1'b1, 8'hFF, 8'hFF, 1'b1);
      check("sat.txn_max", 64'(txn_count), 64'hFFFF_FFFF);
      check("sat.carry_max", 64'(carry_count), 64'hFFFF_FFFF);
`endif
      step("final", 1'b0, 8'h00, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/half_adder_pipe.md
# half_adder_pipe

Registered, lane-parallel half adder with valid/ready handshaking on input and output. For each of WIDTH independent bit lanes it computes Sum = A XOR B and Carry = A AND B. It sits as a leaf arithmetic stage in streaming datapaths, buffering one extra transfer so that upstream ready never depends combinationally on downstream ready.

## Interface
- WIDTH, default 1: number of independent half-adder bit lanes; legal range 1–64.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream transfer offered.
- in_ready  output  1  block can accept a transfer; driven directly from a register.
- A  input  WIDTH  operand A, one bit per lane.
- B  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  result held on Sum/Carry is valid.
- out_ready  input  1  downstream accepts the result.
- Sum  output  WIDTH  per-lane A XOR B.
- Carry  output  WIDTH  per-lane A AND B.
- txn_count  output  32  number of accepted input transfers (HALF_ADDER_STATS_EN only).
- carry_count  output  32  total number of Carry bits set across accepted transfers (HALF_ADDER_STATS_EN only).

## Operation
- Input transfer occurs on a rising clk edge when in_valid && in_ready.
- Output transfer occurs on a rising clk edge when out_valid && out_ready.
- Per lane i: Sum[i] = A[i] ^ B[i] and Carry[i] = A[i] & B[i]. Lanes are fully independent and there is no carry chain between them.
- Storage consists of an output register plus one skid register, for a capacity of 2 results. Results are computed before they are stored.
- The occupancy states are EMPTY, ONE and FULL:
  - EMPTY: an input transfer loads the output register and moves to ONE.
  - ONE with an input and no output: load the skid register and move to FULL.
  - ONE with an output and no input: move to EMPTY.
  - ONE with both an input and an output: reload the output register and stay in ONE.
  - FULL with an output: move the skid register into the output register and go to ONE. No input can be accepted in FULL.
- in_ready = (state != FULL), registered. out_valid = (state != EMPTY).
- Sum and Carry are stable while out_valid && !out_ready.
- Output order equals acceptance order.
- Reset values: state EMPTY, in_ready 1, out_valid 0, Sum 0, Carry 0, counters 0.
- Reset asserted mid-operation discards both stored results immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: data accepted at edge N appears with out_valid high after edge N.
- Throughput is one transfer per cycle while out_ready stays high.
- in_ready drops the cycle after the buffer becomes FULL. It rises the cycle after the first output transfer from FULL.
- No combinational path exists from any input to any output.
- Counters update on the same edge as the input transfer.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Configuration
- HALF_ADDER_STATS_EN defined:
  - txn_count increments by 1 per accepted transfer.
  - carry_count adds popcount(A & B) per accepted transfer.
  - Both counters saturate and reset to 0.
- HALF_ADDER_STATS_EN undefined: txn_count, carry_count and their logic are absent from the port list and the netlist.

## Structure
- Package half_adder_pkg holds:
  - the CNT_W = 32 constant;
  - the occupancy-state enum (EMPTY, ONE, FULL);
  - a saturating-add function for the counters.
- Sub-module half_adder_skid is the 2-entry valid/ready buffer, parameterised on payload width 2*WIDTH. The top level holds the XOR/AND lanes and the optional statistics counters.

## Test plan
- Single-lane truth table, WIDTH=1, out_ready=1:
  - A/B = 0/0, 0/1, 1/0, 1/1 yield Sum/Carry = 0/0, 1/0, 1/0, 0/1.
  - Each result appears one cycle after acceptance.
- Multi-lane, WIDTH=8: A=8'hF0, B=8'h3C yields Sum=8'hCC, Carry=8'h30.
- Backpressure:
  - Hold out_ready=0 and offer 3 transfers. Two are accepted, then in_ready=0.
  - Release out_ready. Results emerge in order and in_ready returns high.
- Reset mid-stream: assert rst while FULL. out_valid=0, in_ready=1, Sum=0 and Carry=0 immediately, before the next clk edge.
- Streaming with HALF_ADDER_STATS_EN, WIDTH=4: 10 back-to-back transfers with A=B=4'hF give txn_count=10 and carry_count=40.
- Saturation: force the counters near the maximum and issue further transfers. Both counters hold at 32'hFFFF_FFFF.
